// File: rtl/booth_mul_issue.sv
// Issue/return front-end for the registered Booth multiplier: request FIFO, operand hold regs, result hold.
// Optional zero-operand short-cut enabled by defining BOOTH_ISSUE_ZERO_BYPASS_EN.
module booth_mul_issue #(
    parameter int N     = 64,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_a,
    input  logic [N-1:0]             in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic [N-1:0]             mul_multiplicand,
    output logic [N-1:0]             mul_multiplier,
    input  logic [2*N-1:0]           mul_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*N-1:0]           out_product,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    // state | meaning
    // IDLE  | nothing in flight, waiting for a queued request
    // ISSUE | operands held on mul_*, multiplier samples at the coming edge
    // WAIT  | mul_product valid, captured at the coming edge
    // HOLD  | result presented until out_ready
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     a_mem_q [DEPTH];
    logic [N-1:0]     a_mem_d [DEPTH];
    logic [N-1:0]     b_mem_q [DEPTH];
    logic [N-1:0]     b_mem_d [DEPTH];
    logic [TAG_W-1:0] t_mem_q [DEPTH];
    logic [TAG_W-1:0] t_mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [N-1:0]     mul_a_q, mul_a_d;
    logic [N-1:0]     mul_b_q, mul_b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             out_valid_q, out_valid_d;
    logic [2*N-1:0]   out_product_q, out_product_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
`ifdef BOOTH_ISSUE_ZERO_BYPASS_EN
    logic             zero_q, zero_d;
`endif
    logic             push;
    logic             load;

    assign in_ready         = (count_q != CW'(DEPTH));
    assign mul_multiplicand = mul_a_q;
    assign mul_multiplier   = mul_b_q;
    assign out_valid        = out_valid_q;
    assign out_product      = out_product_q;
    assign out_tag          = out_tag_q;
    assign fifo_count       = count_q;

    always_comb begin
        a_mem_d       = a_mem_q;
        b_mem_d       = b_mem_q;
        t_mem_d       = t_mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        state_d       = state_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        tag_d         = tag_q;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
        out_tag_d     = out_tag_q;
`ifdef BOOTH_ISSUE_ZERO_BYPASS_EN
        zero_d        = zero_q;
`endif
        load          = 1'b0;
        push          = in_valid && in_ready;

        if (push) begin
            a_mem_d[wr_ptr_q] = in_a;
            b_mem_d[wr_ptr_q] = in_b;
            t_mem_d[wr_ptr_q] = in_tag;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end

        case (state_q)
            S_IDLE:  load = (count_q != '0);
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
`ifdef BOOTH_ISSUE_ZERO_BYPASS_EN
                out_product_d = zero_q ? '0 : mul_product;
`else
                out_product_d = mul_product;
`endif
                out_tag_d   = tag_q;
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    load        = (count_q != '0);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            tag_d    = t_mem_q[rd_ptr_q];
`ifdef BOOTH_ISSUE_ZERO_BYPASS_EN
            // Zero operand: skip the multiplier, WAIT then substitutes a zero product.
            if (a_mem_q[rd_ptr_q] == '0 || b_mem_q[rd_ptr_q] == '0) begin
                zero_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                zero_d  = 1'b0;
                mul_a_d = a_mem_q[rd_ptr_q];
                mul_b_d = b_mem_q[rd_ptr_q];
                state_d = S_ISSUE;
            end
`else
            mul_a_d = a_mem_q[rd_ptr_q];
            mul_b_d = b_mem_q[rd_ptr_q];
            state_d = S_ISSUE;
`endif
        end

        case ({push, load})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                a_mem_q[i] <= '0;
                b_mem_q[i] <= '0;
                t_mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= S_IDLE;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            tag_q         <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            out_tag_q     <= '0;
`ifdef BOOTH_ISSUE_ZERO_BYPASS_EN
            zero_q        <= 1'b0;
`endif
        end else begin
            a_mem_q       <= a_mem_d;
            b_mem_q       <= b_mem_d;
            t_mem_q       <= t_mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            tag_q         <= tag_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            out_tag_q     <= out_tag_d;
`ifdef BOOTH_ISSUE_ZERO_BYPASS_EN
            zero_q        <= zero_d;
`endif
        end
    end

endmodule

// File: tb/tb_booth_mul_issue.sv
// Bench for booth_mul_issue (N=8) with a registered multiplier model and a queue-based reference.
module tb_booth_mul_issue;
    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
`ifdef BOOTH_ISSUE_ZERO_BYPASS_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 3;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_a = '0;
    logic [N-1:0]     in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [N-1:0]     mul_multiplicand;
    logic [N-1:0]     mul_multiplier;
    logic [2*N-1:0]   mul_product;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2*N-1:0]   out_product;
    logic [TAG_W-1:0] out_tag;
    logic [$clog2(DEPTH):0] fifo_count;

    booth_mul_issue #(.N(N), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
        .mul_product(mul_product),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_tag(out_tag),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Registered multiplier stand-in: product one edge after operands are sampled.
    always @(posedge clk or negedge reset) begin
        if (!reset) mul_product <= '0;
        else mul_product <= {{N{mul_multiplicand[N-1]}}, mul_multiplicand}
                          * {{N{mul_multiplier[N-1]}}, mul_multiplier};
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_res = -1;
    int n_res = 0;
    int n_push = 0;
    bit gap_chk = 0;
    bit pushed = 0;
    logic [2*N+TAG_W-1:0] exp_q[$];
    logic [N-1:0] seen_a, seen_b;

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return (2*N)'(sa * sb);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [2*N+TAG_W-1:0] e;
        pushed = 0;
        if (in_valid && in_ready) begin
            exp_q.push_back({ref_mul(in_a, in_b), in_tag});
            pushed = 1;
            n_push++;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_prod", out_product, e[2*N+TAG_W-1:TAG_W]);
                chk("sb_tag", out_tag, e[TAG_W-1:0]);
                if (gap_chk && last_res >= 0) chk("throughput_gap", cyc - last_res, 3);
                last_res = cyc;
                n_res++;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic push_req(input logic [N-1:0] a, input logic [N-1:0] b, input logic [TAG_W-1:0] t);
        int c;
        in_a = a; in_b = b; in_tag = t; in_valid = 1;
        c = 0;
        do begin tick(); c++; end while (!pushed && c < 50);
        chk("push_timeout", pushed, 1);
        in_valid = 0;
    endtask

    task automatic drain();
        int c;
        out_ready = 1;
        c = 0;
        while ((exp_q.size() != 0 || out_valid) && c < 500) begin tick(); c++; end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic single_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [TAG_W-1:0] t,
                             input logic [2*N-1:0] exp_p, input int exp_lat, input string nm);
        int c;
        out_ready = 1;
        in_a = a; in_b = b; in_tag = t; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        c = 0;
        while (!out_valid && c < 10) begin
            @(posedge clk); #1;
            c++;
            if (c == 1) begin seen_a = mul_multiplicand; seen_b = mul_multiplier; end
        end
        chk({nm, "_latency"}, c, exp_lat);
        chk({nm, "_prod"}, out_product, exp_p);
        chk({nm, "_tag"}, out_tag, t);
        @(posedge clk); #1;
        chk({nm, "_released"}, out_valid, 0);
    endtask

    initial begin
        logic [2*N-1:0] held_p;
        logic [N-1:0]   prev_a;
        bit             any_valid;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_mul_a", mul_multiplicand, 0);
        chk("rst_mul_b", mul_multiplier, 0);
        chk("rst_out_product", out_product, 0);
        chk("rst_out_tag", out_tag, 0);
        reset = 1;
        @(posedge clk); #1;

        // Basic and signed directed cases
        single_op(8'd5, 8'd7, 4'd3, 16'h0023, 3, "basic");
        chk("basic_mul_a", seen_a, 8'd5);
        chk("basic_mul_b", seen_b, 8'd7);
        chk("basic_mul_hold", mul_multiplicand, 8'd5);
        single_op(8'hFD, 8'd4, 4'd9, 16'hFFF4, 3, "neg3x4");
        single_op(8'h80, 8'h80, 4'd1, 16'h4000, 3, "min_sq");

        // Backpressure, full FIFO, push refilling a slot freed by a pop
        out_ready = 0;
        for (int i = 0; i < 5; i++)
            push_req(8'(8'h11 * (i + 1)), 8'(8'hF3 - 8'(7 * i)), 4'(i + 1));
        repeat (3) tick();
        chk("full_count", fifo_count, DEPTH);
        chk("full_in_ready", in_ready, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_first_prod", out_product, ref_mul(8'h11, 8'hF3));
        chk("bp_first_tag", out_tag, 1);
        held_p = out_product;
        in_a = 8'h7F; in_b = 8'h81; in_tag = 4'd6; in_valid = 1;
        repeat (4) tick();
        chk("bp_stable_prod", out_product, held_p);
        chk("bp_stable_valid", out_valid, 1);
        chk("full_no_push", n_push, 5);
        chk("full_count_hold", fifo_count, DEPTH);
        gap_chk = 1;
        last_res = -1;
        n_res = 0;
        out_ready = 1;
        begin
            int c = 0;
            do begin tick(); c++; end while (!pushed && c < 50);
            chk("refill_push", pushed, 1);
        end
        in_valid = 0;
        chk("refill_count", fifo_count, DEPTH);
        drain();
        chk("bp_result_count", n_res, 6);
        gap_chk = 0;

        // Reset while the first of two requests sits in WAIT
        out_ready = 1;
        in_a = 8'd9; in_b = 8'd9; in_tag = 4'd2; in_valid = 1;
        @(posedge clk); #1;
        in_a = 8'd3; in_tag = 4'd4;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        reset = 0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_count", fifo_count, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        any_valid = 0;
        repeat (6) begin @(posedge clk); #1; any_valid |= out_valid; end
        chk("midrst_no_result", any_valid, 0);
        chk("midrst_empty", fifo_count, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_prod_clear", out_product, 0);

        // Zero operand
        prev_a = mul_multiplicand;
        single_op(8'h00, 8'h55, 4'd5, 16'h0000, ZLAT, "zero");
`ifdef BOOTH_ISSUE_ZERO_BYPASS_EN
        chk("zero_mul_untouched", mul_multiplicand, prev_a);
`else
        chk("zero_mul_loaded", mul_multiplier, 8'h55);
`endif

        // Random traffic with random consumer backpressure
        n_push = 0;
        n_res = 0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || pushed) begin
                in_valid = (n_push < 40) && ($urandom_range(0, 3) != 0);
                in_a = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
                in_b = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
                in_tag = TAG_W'($urandom);
            end
            out_ready = $urandom_range(0, 1);
            tick();
        end
        in_valid = 0;
        drain();
        chk("rand_result_count", n_res, n_push);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
